// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 burst master.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam int unsigned AXI_4KB   = 4096;

  // A burst is refused when it is not word aligned or when its last byte
  // would fall beyond the 4KB page that holds its first byte.
  function automatic logic burst_illegal(input logic [11:0] offset,
                                         input logic [7:0]  len);
    logic [13:0] end_byte;
    end_byte = {2'b00, offset} + {4'b0000, len, 2'b00} + 14'd4;
    return (end_byte > 14'(AXI_4KB)) || (offset[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/axi_burst_beat_cnt.sv
// Beat counter shared by the write-data and read-data phases. Cleared when
// a command is accepted, advanced on each data handshake; 'last' flags the
// beat whose index equals the AXI len of the burst.
module axi_burst_beat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last
);

  logic [7:0] count;

  // Beat index register: cleared on load, +1 per handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign last = (count == len);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 initiator: one INCR burst (write AW/W/B or read AR/R) per accepted
// command, at most one outstanding. Write and read data stream straight
// through to/from the AXI W and R channels with zero latency.
// Optional build macro AXI_BURST_MASTER_STATS_EN adds saturating beat and
// error counters on extra output ports.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  AXCACHE = 4'b0011,
  parameter logic [2:0]  AXPROT  = 3'b000
) (
  input  logic                m_axi_aclk,
  input  logic                m_axi_aresetn,
  // command interface
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  // write data stream
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  // read data stream
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  // completion
  output logic                done_valid,
  output logic [1:0]          done_resp,
  // AXI write address
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // AXI write response
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
`ifdef AXI_BURST_MASTER_STATS_EN
  ,
  output logic [31:0]         stat_wr_beats,
  output logic [31:0]         stat_rd_beats,
  output logic [15:0]         stat_err_cnt
`endif
);

  state_e            state, state_nxt;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic              write_q;
  logic [1:0]        resp_q;
  logic              guard_err_q;

  logic cmd_hs;
  logic w_hs;
  logic r_hs;
  logic bad_cmd;
  logic beat_last;

  // cmd_ready comes from a register so it is low while reset is asserted
  // and rises on the first clock after release.
  assign cmd_ready = ready_q;
  assign cmd_hs    = cmd_valid && ready_q;
  assign w_hs      = (state == ST_W) && wr_valid && m_axi_wready;
  assign r_hs      = (state == ST_R) && m_axi_rvalid && rd_ready;
  assign bad_cmd   = burst_illegal(addr_q[11:0], len_q);

  axi_burst_beat_cnt u_beat_cnt (
    .clk   (m_axi_aclk),
    .rst_n (m_axi_aresetn),
    .load  (cmd_hs),
    .inc   (w_hs || r_hs),
    .len   (len_q),
    .last  (beat_last)
  );

  // Address/len are held in registers, so they stay stable under valid.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awcache = AXCACHE;
  assign m_axi_awprot  = AXPROT;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = AXCACHE;
  assign m_axi_arprot  = AXPROT;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;

  // FSM state register; reset aborts any burst straight back to IDLE.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
    end
  end

  // Next-state decode plus all handshake/valid outputs for the current state.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done_valid    = 1'b0;
    done_resp     = AXI_RESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (cmd_hs) state_nxt = ST_CHK;
      end
      ST_CHK: begin
        if (bad_cmd)      state_nxt = ST_DONE;
        else if (write_q) state_nxt = ST_AW;
        else              state_nxt = ST_AR;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = beat_last;
        if (w_hs && beat_last) state_nxt = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = ST_DONE;
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = ST_R;
      end
      ST_R: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        rd_last      = m_axi_rlast;
        if (r_hs && m_axi_rlast) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_valid = 1'b1;
        done_resp  = guard_err_q ? AXI_RESP_SLVERR : resp_q;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture and response accumulation for the burst in flight.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_q      <= '0;
      len_q       <= 8'd0;
      write_q     <= 1'b0;
      resp_q      <= AXI_RESP_OKAY;
      guard_err_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q      <= cmd_addr;
        len_q       <= cmd_len;
        write_q     <= cmd_write;
        resp_q      <= AXI_RESP_OKAY;
        guard_err_q <= 1'b0;
      end
      if (state == ST_CHK && bad_cmd) begin
        resp_q <= AXI_RESP_SLVERR;
      end
      if (state == ST_B && m_axi_bvalid) begin
        resp_q <= m_axi_bresp;
      end
      if (r_hs) begin
        if (m_axi_rresp > resp_q) resp_q <= m_axi_rresp;
        // rlast must coincide with beat len; anything else is a protocol
        // error from the slave, but the burst is still drained to rlast.
        if (m_axi_rlast != beat_last) guard_err_q <= 1'b1;
      end
    end
  end

`ifdef AXI_BURST_MASTER_STATS_EN
  // Saturating activity counters: W beats, R beats, failed bursts.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      stat_wr_beats <= 32'd0;
      stat_rd_beats <= 32'd0;
      stat_err_cnt  <= 16'd0;
    end else begin
      if (w_hs && (stat_wr_beats != '1)) stat_wr_beats <= stat_wr_beats + 32'd1;
      if (r_hs && (stat_rd_beats != '1)) stat_rd_beats <= stat_rd_beats + 32'd1;
      if (done_valid && (done_resp != AXI_RESP_OKAY) && (stat_err_cnt != '1)) begin
        stat_err_cnt <= stat_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: an AXI slave with a word
// memory, a stream source/sink, a table of directed bursts, a reset-abort
// sequence and randomized bursts checked against a behavioural model.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
`ifdef AXI_BURST_MASTER_STATS_EN
  logic [31:0] stat_wr_beats, stat_rd_beats;
  logic [15:0] stat_err_cnt;
`endif

  initial forever #5 clk = ~clk;

  axi_burst_master dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXI_BURST_MASTER_STATS_EN
    ,
    .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats), .stat_err_cnt(stat_err_cnt)
`endif
  );

  // One directed or random burst with its slave behaviour and expected result.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          b_stall;
    logic [1:0]  b_resp;
    int          err_beat;   // read beat carrying err_val, -1 for none
    logic [1:0]  err_val;
    int          r_beats;    // beats the slave returns, 0 means len+1
    int          rd_mode;    // 0 always ready, 1 toggling, 2 random
    int          rdy_pct;    // slave ready probability in percent
    logic [1:0]  exp_resp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Slave memory and the bench's own model of what it should contain.
  logic [31:0] smem    [4096];
  logic [31:0] ref_mem [4096];

  // Slave-side knobs and state.
  int         b_stall_k, r_err_beat_k, r_beats_k, rd_mode_k, rdy_pct_k;
  logic [1:0] b_resp_k, r_err_val_k;
  int         w_ptr, r_ptr, r_idx, r_n, b_cnt;
  logic       b_pend, r_act;

  // Observations of one burst.
  logic [31:0] wq[$];
  logic [31:0] obs_w_data[$], obs_r_data[$];
  logic        obs_w_last[$], obs_r_last[$];
  logic        saw_aw, saw_ar;
  logic [31:0] obs_addr;
  logic [7:0]  obs_len;
  int          done_cnt, done_cyc, acc_cyc, cyc;
  logic [1:0]  done_resp_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic roll();
    return $urandom_range(99) < rdy_pct_k;
  endfunction

  // Reference rules: refused when misaligned or crossing a 4KB page.
  function automatic logic model_reject(input logic [31:0] a, input logic [7:0] l);
    int unsigned end_byte;
    end_byte = (a % 32'd4096) + 4 * (int'(l) + 1);
    return ((a % 32'd4) != 0) || (end_byte > 4096);
  endfunction

  function automatic logic [1:0] model_resp(input vec_t v);
    int         nb;
    logic [1:0] worst;
    if (model_reject(v.addr, v.len)) return AXI_RESP_SLVERR;
    if (v.wr) return v.b_resp;
    nb = (v.r_beats > 0) ? v.r_beats : int'(v.len) + 1;
    worst = AXI_RESP_OKAY;
    for (int i = 0; i < nb; i++)
      if (i == v.err_beat && v.err_val > worst) worst = v.err_val;
    if (nb != int'(v.len) + 1) return AXI_RESP_SLVERR;
    return worst;
  endfunction

  task automatic clear_slave();
    b_pend = 1'b0; r_act = 1'b0; b_cnt = 0; r_idx = 0; r_n = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rdata = 32'd0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0; cmd_valid = 1'b0;
    wq.delete();
  endtask

  // One clock: settle, sample handshakes, update models, pass the edge,
  // then drive the next cycle's inputs at the falling edge.
  task automatic cycle();
    logic hs_cmd, hs_aw, hs_w, hs_wr, hs_b, hs_ar, hs_r, hs_rd;
    #1;
    hs_cmd = cmd_valid && cmd_ready;
    hs_aw  = m_axi_awvalid && m_axi_awready;
    hs_w   = m_axi_wvalid && m_axi_wready;
    hs_wr  = wr_valid && wr_ready;
    hs_b   = m_axi_bvalid && m_axi_bready;
    hs_ar  = m_axi_arvalid && m_axi_arready;
    hs_r   = m_axi_rvalid && m_axi_rready;
    hs_rd  = rd_valid && rd_ready;
    if (m_axi_awvalid) saw_aw = 1'b1;
    if (m_axi_arvalid) saw_ar = 1'b1;
    if (done_valid) begin done_cnt++; done_resp_s = done_resp; done_cyc = cyc; end
    if (hs_cmd) acc_cyc = cyc;
    if (hs_aw) begin w_ptr = int'(m_axi_awaddr[13:2]); obs_addr = m_axi_awaddr; obs_len = m_axi_awlen; end
    if (hs_w) begin
      smem[w_ptr & 4095] = m_axi_wdata;
      obs_w_data.push_back(m_axi_wdata);
      obs_w_last.push_back(m_axi_wlast);
      w_ptr++;
      if (m_axi_wlast) begin b_pend = 1'b1; b_cnt = b_stall_k; end
    end
    if (hs_wr && wq.size() > 0) void'(wq.pop_front());
    if (hs_b) b_pend = 1'b0;
    if (hs_ar) begin
      r_act = 1'b1; r_ptr = int'(m_axi_araddr[13:2]); r_idx = 0;
      r_n = (r_beats_k > 0) ? r_beats_k : int'(m_axi_arlen) + 1;
      obs_addr = m_axi_araddr; obs_len = m_axi_arlen;
    end
    if (hs_r) begin r_idx++; if (r_idx >= r_n) r_act = 1'b0; end
    if (hs_rd) begin obs_r_data.push_back(rd_data); obs_r_last.push_back(rd_last); end
    @(negedge clk);
    cyc++;
    if (hs_cmd) cmd_valid = 1'b0;
    m_axi_awready = roll();
    m_axi_wready  = roll();
    m_axi_arready = roll();
    if (b_pend) begin
      if (b_cnt > 0) begin b_cnt--; m_axi_bvalid = 1'b0; end
      else begin m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_k; end
    end else m_axi_bvalid = 1'b0;
    if (r_act) begin
      m_axi_rdata = smem[(r_ptr + r_idx) & 4095];
      m_axi_rresp = (r_idx == r_err_beat_k) ? r_err_val_k : AXI_RESP_OKAY;
      m_axi_rlast = (r_idx == r_n - 1);
      if (!m_axi_rvalid || hs_r) m_axi_rvalid = roll();
    end else m_axi_rvalid = 1'b0;
    if (wq.size() > 0) begin
      wr_data = wq[0];
      if (!wr_valid || hs_wr) wr_valid = roll();
    end else wr_valid = 1'b0;
    case (rd_mode_k)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ~rd_ready;
      default: rd_ready = roll();
    endcase
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic        rej;
    logic [31:0] exp_w[$];
    int          nb, bad_d, bad_l, base;
    rej = model_reject(v.addr, v.len);
    b_stall_k = v.b_stall; b_resp_k = v.b_resp; r_err_beat_k = v.err_beat;
    r_err_val_k = v.err_val; r_beats_k = v.r_beats; rd_mode_k = v.rd_mode; rdy_pct_k = v.rdy_pct;
    obs_w_data.delete(); obs_w_last.delete(); obs_r_data.delete(); obs_r_last.delete();
    saw_aw = 1'b0; saw_ar = 1'b0; done_cnt = 0; acc_cyc = -100; done_cyc = 0;
    obs_addr = 32'd0; obs_len = 8'd0;
    wq.delete();
    if (v.wr && !rej)
      for (int i = 0; i <= int'(v.len); i++) begin
        exp_w.push_back($urandom);
        wq.push_back(exp_w[i]);
      end
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) cycle();
    cycle(); cycle();
    cmd_valid = 1'b0;
    check($sformatf("v%0d_done_seen", id), done_cnt != 0, 1);
    check($sformatf("v%0d_done_once", id), done_cnt, 1);
    check($sformatf("v%0d_resp", id), done_resp_s, v.exp_resp);
    if (rej) begin
      check($sformatf("v%0d_no_axi", id), {saw_aw, saw_ar}, 0);
      check($sformatf("v%0d_latency", id), done_cyc - acc_cyc, 2);
    end else begin
      check($sformatf("v%0d_addr_len", id), {obs_addr, obs_len}, {v.addr, v.len});
      base = int'(v.addr[13:2]);
      bad_d = 0; bad_l = 0;
      if (v.wr) begin
        nb = int'(v.len) + 1;
        check($sformatf("v%0d_w_beats", id), obs_w_data.size(), nb);
        for (int i = 0; i < obs_w_data.size() && i < nb; i++) begin
          if (obs_w_data[i] !== exp_w[i]) bad_d++;
          if (obs_w_last[i] !== (i == nb - 1)) bad_l++;
        end
        for (int i = 0; i < nb; i++) ref_mem[(base + i) & 4095] = exp_w[i];
      end else begin
        nb = (v.r_beats > 0) ? v.r_beats : int'(v.len) + 1;
        check($sformatf("v%0d_r_beats", id), obs_r_data.size(), nb);
        for (int i = 0; i < obs_r_data.size() && i < nb; i++) begin
          if (obs_r_data[i] !== ref_mem[(base + i) & 4095]) bad_d++;
          if (obs_r_last[i] !== (i == nb - 1)) bad_l++;
        end
      end
      check($sformatf("v%0d_data_errs", id), bad_d, 0);
      check($sformatf("v%0d_last_errs", id), bad_l, 0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_word;
    //          wr    addr          len   bst  bresp  ebeat eval   rb  mode pct  exp
    vecs[0]  = '{1'b1, 32'h6000_0000, 8'd3, 5, 2'b00, -1, 2'b00, 0, 0, 100, 2'b00};
    vecs[1]  = '{1'b0, 32'h6000_0100, 8'd7, 0, 2'b00, -1, 2'b00, 0, 1, 100, 2'b00};
    vecs[2]  = '{1'b1, 32'h6000_0FF8, 8'd3, 0, 2'b00, -1, 2'b00, 0, 0, 100, 2'b10};
    vecs[3]  = '{1'b0, 32'h6000_0200, 8'd3, 0, 2'b00,  1, 2'b11, 0, 0, 100, 2'b11};
    vecs[4]  = '{1'b0, 32'h6000_0102, 8'd0, 0, 2'b00, -1, 2'b00, 0, 0, 100, 2'b10};
    vecs[5]  = '{1'b1, 32'h6000_0FF0, 8'd3, 1, 2'b01, -1, 2'b00, 0, 2,  60, 2'b01};
    vecs[6]  = '{1'b0, 32'h6000_0FF0, 8'd3, 0, 2'b00, -1, 2'b00, 0, 2,  60, 2'b00};
    vecs[7]  = '{1'b0, 32'h6000_0300, 8'd3, 0, 2'b00, -1, 2'b00, 2, 0, 100, 2'b10};
    vecs[8]  = '{1'b0, 32'h6000_0400, 8'd3, 0, 2'b00, -1, 2'b00, 6, 0, 100, 2'b10};
    vecs[9]  = '{1'b1, 32'h6000_0500, 8'd0, 2, 2'b10, -1, 2'b00, 0, 0, 100, 2'b10};
    vecs[10] = '{1'b0, 32'h6000_0000, 8'd3, 0, 2'b00, -1, 2'b00, 0, 2,  50, 2'b00};

    for (int i = 0; i < 4096; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    rdy_pct_k = 100; rd_mode_k = 0;
    cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0; wr_strb = 4'hF;
    cyc = 0;
    clear_slave();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valids_readies",
          {cmd_ready, wr_ready, rd_valid, done_valid, m_axi_awvalid, m_axi_wvalid,
           m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("reset_done_resp", done_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("const_size_burst", {m_axi_awsize, m_axi_arsize, m_axi_awburst, m_axi_arburst},
          {3'b010, 3'b010, 2'b01, 2'b01});
    check("const_cache_prot", {m_axi_awcache, m_axi_arcache, m_axi_awprot, m_axi_arprot},
          {4'b0011, 4'b0011, 3'b000, 3'b000});

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
`ifdef AXI_BURST_MASTER_STATS_EN
      if (i == 1) begin
        check("stat_wr_beats", stat_wr_beats, 4);
        check("stat_rd_beats", stat_rd_beats, 8);
        check("stat_err_cnt", stat_err_cnt, 0);
      end
`endif
    end

    // Reset asserted while the second of four write beats is on the bus.
    rdy_pct_k = 100; rd_mode_k = 0; b_stall_k = 0; r_beats_k = 0;
    obs_w_data.delete(); obs_w_last.delete();
    first_word = $urandom;
    wq.push_back(first_word);
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000_0800; cmd_len = 8'd3;
    for (int k = 0; k < 200 && obs_w_data.size() == 0; k++) cycle();
    #1;
    check("rst_mid_beat2_wvalid", m_axi_wvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_async_zero",
          {cmd_ready, wr_ready, rd_valid, done_valid, m_axi_awvalid, m_axi_wvalid,
           m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    ref_mem[32'h800 >> 2] = first_word;
    clear_slave();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_cmd_ready_after", cmd_ready, 1);

    // Randomized bursts against the behavioural model.
    for (int n = 0; n < 24; n++) begin
      vec_t r;
      r.wr       = 1'($urandom_range(1));
      r.addr     = 32'h6000_0000 | (32'($urandom_range(4095)) << 2);
      if ($urandom_range(7) == 0) r.addr[1] = 1'b1;
      r.len      = 8'($urandom_range(15));
      r.b_stall  = $urandom_range(3);
      r.b_resp   = 2'($urandom_range(3));
      r.err_beat = ($urandom_range(1) == 1) ? int'($urandom_range(15)) : -1;
      r.err_val  = 2'($urandom_range(3));
      r.r_beats  = 0;
      r.rd_mode  = 2;
      r.rdy_pct  = $urandom_range(40, 100);
      r.exp_resp = model_resp(r);
      run_vec(r, 100 + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
